// File: rtl/fadd_pkg.sv
// rtl/fadd_pkg.sv - shared FP-adder types, flag indices and constant results
package fadd_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_e;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    // Results are built in 64 bits and sliced by the user to {sign, exp, mant}.
    function automatic logic [63:0] canon_nan(input int ew, input int pc);
        return (((64'd1 << ew) - 64'd1) << pc) | (64'd1 << (pc - 1));
    endfunction

    function automatic logic [63:0] max_finite(input logic sign, input int ew, input int pc);
        return ({63'd0, sign} << (ew + pc))
             | (((64'd1 << ew) - 64'd2) << pc)
             | ((64'd1 << pc) - 64'd1);
    endfunction

endpackage

// File: rtl/fadd_round_inc.sv
// rtl/fadd_round_inc.sv - round-increment decision from rm, sign, lsb, guard and sticky
module fadd_round_inc
    import fadd_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    output logic       inc_o,
    output logic       inexact_o
);

    // Reserved encodings fall through to round-to-nearest-even.
    always_comb begin
        inc_o = guard_i & (sticky_i | lsb_i);
        case (rm_e'(rm_i))
            RTZ:     inc_o = 1'b0;
            RDN:     inc_o = sign_i & (guard_i | sticky_i);
            RUP:     inc_o = ~sign_i & (guard_i | sticky_i);
            RMM:     inc_o = guard_i;
            default: inc_o = guard_i & (sticky_i | lsb_i);
        endcase
    end

    assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fadd_s2.sv
// rtl/fadd_s2.sv - final FP-adder stage: path select, round, pack; flags gated by FADD_S2_FFLAGS_EN
module fadd_s2
    import fadd_pkg::*;
#(
    parameter int EXPWIDTH = 5,
    parameter int OUTPC    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [2:0]                in_rm_i,
    input  logic                      in_far_sign_i,
    input  logic                      in_near_sign_i,
    input  logic [EXPWIDTH-1:0]       in_far_exp_i,
    input  logic [EXPWIDTH-1:0]       in_near_exp_i,
    input  logic [OUTPC+2:0]          in_far_frac_i,
    input  logic [OUTPC+2:0]          in_near_frac_i,
    input  logic                      in_sel_far_path_i,
    input  logic                      in_special_case_nan_i,
    input  logic                      in_special_case_inf_i,
    input  logic                      in_special_case_inf_sign_i,
    input  logic                      in_special_case_iv_i,
    input  logic                      in_far_mul_of_i,
    input  logic                      in_near_sig_is_zero_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [EXPWIDTH+OUTPC:0]   out_result_o,
    output logic [4:0]                out_fflags_o
);

    localparam int FW = OUTPC + 3;
    localparam int SW = EXPWIDTH + OUTPC;
    localparam int RW = SW + 1;

    localparam logic [63:0]         NAN_W    = canon_nan(EXPWIDTH, OUTPC);
    localparam logic [63:0]         MAXP_W   = max_finite(1'b0, EXPWIDTH, OUTPC);
    localparam logic [63:0]         MAXN_W   = max_finite(1'b1, EXPWIDTH, OUTPC);
    localparam logic [RW-1:0]       NAN_RES  = NAN_W[RW-1:0];
    localparam logic [RW-1:0]       MAXP_RES = MAXP_W[RW-1:0];
    localparam logic [RW-1:0]       MAXN_RES = MAXN_W[RW-1:0];
    localparam logic [EXPWIDTH-1:0] EXP_ONES = '1;

    logic stall;
    logic advance;

    assign stall      = out_valid_o & ~out_ready_i;
    assign advance    = ~stall;
    assign in_ready_o = advance;

    logic                sel_sign;
    logic [EXPWIDTH-1:0] sel_exp;
    logic [FW-1:0]       sel_frac;
    logic                rnd_inc;
    logic                rnd_inexact;

    assign sel_sign = in_sel_far_path_i ? in_far_sign_i : in_near_sign_i;
    assign sel_exp  = in_sel_far_path_i ? in_far_exp_i  : in_near_exp_i;
    assign sel_frac = in_sel_far_path_i ? in_far_frac_i : in_near_frac_i;

    fadd_round_inc u_round_inc (
        .rm_i      (in_rm_i),
        .sign_i    (sel_sign),
        .lsb_i     (sel_frac[2]),
        .guard_i   (sel_frac[1]),
        .sticky_i  (sel_frac[0]),
        .inc_o     (rnd_inc),
        .inexact_o (rnd_inexact)
    );

    // The hidden bit is implied by the exponent, so it is never consumed here.
    logic unused_bits;
`ifdef FADD_S2_FFLAGS_EN
    assign unused_bits = sel_frac[FW-1];
`else
    assign unused_bits = ^{sel_frac[FW-1], rnd_inexact, in_special_case_iv_i};
`endif

    logic                a_valid_q;
    logic                a_sign_q;
    logic [EXPWIDTH-1:0] a_exp_q;
    logic [OUTPC-1:0]    a_mant_q;
    logic                a_inc_q;
    rm_e                 a_rm_q;
    logic                a_nan_q;
    logic                a_inf_q;
    logic                a_inf_sign_q;
    logic                a_mul_of_q;
    logic                a_zero_q;
`ifdef FADD_S2_FFLAGS_EN
    logic                a_inexact_q;
    logic                a_iv_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q    <= 1'b0;
            a_sign_q     <= 1'b0;
            a_exp_q      <= '0;
            a_mant_q     <= '0;
            a_inc_q      <= 1'b0;
            a_rm_q       <= RNE;
            a_nan_q      <= 1'b0;
            a_inf_q      <= 1'b0;
            a_inf_sign_q <= 1'b0;
            a_mul_of_q   <= 1'b0;
            a_zero_q     <= 1'b0;
`ifdef FADD_S2_FFLAGS_EN
            a_inexact_q  <= 1'b0;
            a_iv_q       <= 1'b0;
`endif
        end else if (advance) begin
            a_valid_q <= in_valid_i;
            if (in_valid_i) begin
                a_sign_q     <= sel_sign;
                a_exp_q      <= sel_exp;
                a_mant_q     <= sel_frac[FW-2:2];
                a_inc_q      <= rnd_inc;
                a_rm_q       <= rm_e'(in_rm_i);
                a_nan_q      <= in_special_case_nan_i;
                a_inf_q      <= in_special_case_inf_i;
                a_inf_sign_q <= in_special_case_inf_sign_i;
                a_mul_of_q   <= in_far_mul_of_i;
                a_zero_q     <= in_near_sig_is_zero_i & ~in_sel_far_path_i;
`ifdef FADD_S2_FFLAGS_EN
                a_inexact_q  <= rnd_inexact;
                a_iv_q       <= in_special_case_iv_i;
`endif
            end
        end
    end

    // A mantissa carry ripples straight into the exponent field, which also
    // promotes a carrying subnormal to exponent 1.
    logic [SW-1:0]       sum;
    logic [EXPWIDTH-1:0] sum_exp;
    logic                ovf;
    logic                ovf_to_max;

    assign sum        = {a_exp_q, a_mant_q} + SW'(a_inc_q);
    assign sum_exp    = sum[SW-1:OUTPC];
    assign ovf        = (sum_exp == EXP_ONES) | a_mul_of_q;
    assign ovf_to_max = (a_rm_q == RTZ) | ((a_rm_q == RDN) & ~a_sign_q)
                      | ((a_rm_q == RUP) & a_sign_q);

    logic [RW-1:0] result_d;
    logic [RW-1:0] out_result_q;
    logic          out_valid_q;
`ifdef FADD_S2_FFLAGS_EN
    logic [4:0]    fflags_d;
    logic [4:0]    out_fflags_q;
`endif

    always_comb begin
        result_d = {a_sign_q, sum};
`ifdef FADD_S2_FFLAGS_EN
        fflags_d = '0;
`endif
        if (a_nan_q) begin
            result_d = NAN_RES;
`ifdef FADD_S2_FFLAGS_EN
            fflags_d[FF_NV] = a_iv_q;
`endif
        end else if (a_inf_q) begin
            result_d = {a_inf_sign_q, EXP_ONES, {OUTPC{1'b0}}};
`ifdef FADD_S2_FFLAGS_EN
            fflags_d[FF_NV] = a_iv_q;
`endif
        end else if (a_zero_q) begin
            result_d         = '0;
            result_d[RW-1]   = (a_rm_q == RDN);
        end else if (ovf) begin
            if (ovf_to_max) begin
                result_d = a_sign_q ? MAXN_RES : MAXP_RES;
            end else begin
                result_d = {a_sign_q, EXP_ONES, {OUTPC{1'b0}}};
            end
`ifdef FADD_S2_FFLAGS_EN
            fflags_d[FF_OF] = 1'b1;
            fflags_d[FF_NX] = 1'b1;
`endif
        end else begin
`ifdef FADD_S2_FFLAGS_EN
            fflags_d[FF_NX] = a_inexact_q;
            fflags_d[FF_UF] = a_inexact_q & (sum_exp == '0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
`ifdef FADD_S2_FFLAGS_EN
            out_fflags_q <= '0;
`endif
        end else if (advance) begin
            out_valid_q <= a_valid_q;
            if (a_valid_q) begin
                out_result_q <= result_d;
`ifdef FADD_S2_FFLAGS_EN
                out_fflags_q <= fflags_d;
`endif
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
`ifdef FADD_S2_FFLAGS_EN
    assign out_fflags_o = out_fflags_q;
`else
    assign out_fflags_o = 5'b0;
`endif

endmodule

// File: tb/tb_fadd_s2.sv
// tb/tb_fadd_s2.sv - self-checking bench for fadd_s2 with a result scoreboard
module tb_fadd_s2;

`ifdef FADD_S2_FFLAGS_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    typedef struct packed {
        logic       far;
        logic       sign;
        logic [4:0] ex;
        logic [6:0] frac;
        logic [2:0] rm;
        logic       nan;
        logic       inf;
        logic       inf_sign;
        logic       iv;
        logic       mul_of;
        logic       zero;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [2:0] in_rm_i;
    logic       in_far_sign_i, in_near_sign_i;
    logic [4:0] in_far_exp_i, in_near_exp_i;
    logic [6:0] in_far_frac_i, in_near_frac_i;
    logic       in_sel_far_path_i;
    logic       in_special_case_nan_i, in_special_case_inf_i;
    logic       in_special_case_inf_sign_i, in_special_case_iv_i;
    logic       in_far_mul_of_i, in_near_sig_is_zero_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [9:0] out_result_o;
    logic [4:0] out_fflags_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [14:0] sb[$];

    fadd_s2 dut (
        .clk                        (clk),
        .rst                        (rst),
        .in_valid_i                 (in_valid_i),
        .in_ready_o                 (in_ready_o),
        .in_rm_i                    (in_rm_i),
        .in_far_sign_i              (in_far_sign_i),
        .in_near_sign_i             (in_near_sign_i),
        .in_far_exp_i               (in_far_exp_i),
        .in_near_exp_i              (in_near_exp_i),
        .in_far_frac_i              (in_far_frac_i),
        .in_near_frac_i             (in_near_frac_i),
        .in_sel_far_path_i          (in_sel_far_path_i),
        .in_special_case_nan_i      (in_special_case_nan_i),
        .in_special_case_inf_i      (in_special_case_inf_i),
        .in_special_case_inf_sign_i (in_special_case_inf_sign_i),
        .in_special_case_iv_i       (in_special_case_iv_i),
        .in_far_mul_of_i            (in_far_mul_of_i),
        .in_near_sig_is_zero_i      (in_near_sig_is_zero_i),
        .out_valid_o                (out_valid_o),
        .out_ready_i                (out_ready_i),
        .out_result_o               (out_result_o),
        .out_fflags_o               (out_fflags_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ffm(input logic [4:0] f);
        return FF_EN ? f : 5'b0;
    endfunction

    function automatic vec_t mk(input logic far, input logic sign, input logic [4:0] ex,
                                input logic [6:0] frac, input logic [2:0] rm,
                                input logic nan, input logic inf, input logic inf_sign,
                                input logic iv, input logic mul_of, input logic zero);
        vec_t v;
        v = '{far, sign, ex, frac, rm, nan, inf, inf_sign, iv, mul_of, zero};
        return v;
    endfunction

    // Reference: {fflags, result} for EXPWIDTH=5, OUTPC=4, exponents kept below 31.
    function automatic logic [14:0] model(input vec_t v);
        logic [3:0] m;
        logic       g, s, inc, mx;
        logic [9:0] sum, r;
        logic [4:0] f;
        m = v.frac[5:2];
        g = v.frac[1];
        s = v.frac[0];
        case (v.rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = v.sign & (g | s);
            3'd3:    inc = ~v.sign & (g | s);
            3'd4:    inc = g;
            default: inc = g & (s | m[0]);
        endcase
        sum = {1'b0, v.ex, m} + {9'd0, inc};
        f = 5'b0;
        if (v.nan) begin
            r = 10'h1F8;
            f[4] = v.iv;
        end else if (v.inf) begin
            r = {v.inf_sign, 9'h1F0};
            f[4] = v.iv;
        end else if (v.zero && !v.far) begin
            r = (v.rm == 3'd2) ? 10'h200 : 10'h000;
        end else if (sum[8:4] == 5'd31 || v.mul_of) begin
            mx = (v.rm == 3'd1) || (v.rm == 3'd2 && !v.sign) || (v.rm == 3'd3 && v.sign);
            r = mx ? {v.sign, 9'h1EF} : {v.sign, 9'h1F0};
            f = 5'b00101;
        end else begin
            r = {v.sign, sum[8:0]};
            f[0] = g | s;
            f[1] = (g | s) && (sum[8:4] == 5'd0);
        end
        return {ffm(f), r};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 30)), 7'($urandom), 3'($urandom_range(0, 7)),
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        in_valid_i                 = 1'b1;
        in_rm_i                    = v.rm;
        in_sel_far_path_i          = v.far;
        in_far_sign_i              = v.far ? v.sign : 1'($urandom);
        in_near_sign_i             = v.far ? 1'($urandom) : v.sign;
        in_far_exp_i               = v.far ? v.ex : 5'($urandom);
        in_near_exp_i              = v.far ? 5'($urandom) : v.ex;
        in_far_frac_i              = v.far ? v.frac : 7'($urandom);
        in_near_frac_i             = v.far ? 7'($urandom) : v.frac;
        in_special_case_nan_i      = v.nan;
        in_special_case_inf_i      = v.inf;
        in_special_case_inf_sign_i = v.inf_sign;
        in_special_case_iv_i       = v.iv;
        in_far_mul_of_i            = v.mul_of;
        in_near_sig_is_zero_i      = v.zero;
    endtask

    task automatic idle();
        apply('0);
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (out_result_o !== 10'h0) begin n_err++; $display("FAIL reset_result: got %h want 000", out_result_o); end
        n_cmp++; if (out_fflags_o !== 5'h0) begin n_err++; $display("FAIL reset_fflags: got %b want 00000", out_fflags_o); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    endtask

    task automatic test_rounding();
        vec_t        v[$];
        logic [14:0] e[$];
        logic [14:0] x;
        int          idx = 0;
        int          cyc = 0;
        v.push_back(mk(1, 0, 15, 7'b1101010, 3'd0, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h0FA});
        v.push_back(mk(1, 0, 15, 7'b1101110, 3'd0, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h0FC});
        v.push_back(mk(1, 0, 15, 7'b1111111, 3'd0, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h100});
        v.push_back(mk(1, 0, 30, 7'b1111110, 3'd0, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00101), 10'h1F0});
        v.push_back(mk(1, 0, 30, 7'b1111110, 3'd1, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h1EF});
        v.push_back(mk(1, 1, 30, 7'b1111110, 3'd3, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h3EF});
        v.push_back(mk(1, 0, 0,  7'b0000110, 3'd1, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00011), 10'h001});
        v.push_back(mk(1, 0, 0,  7'b0111111, 3'd0, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h010});
        v.push_back(mk(1, 0, 15, 7'b1101110, 3'd5, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h0FC});
        v.push_back(mk(1, 0, 15, 7'b1101010, 3'd4, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h0FB});
        v.push_back(mk(0, 1, 15, 7'b1101001, 3'd2, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00001), 10'h2FB});
        v.push_back(mk(1, 0, 15, 7'b1101000, 3'd0, 0, 0, 0, 0, 0, 0)); e.push_back({ffm(5'b00000), 10'h0FA});
        v.push_back(mk(1, 0, 10, 7'b1000000, 3'd2, 0, 0, 0, 0, 1, 0)); e.push_back({ffm(5'b00101), 10'h1EF});
        out_ready_i = 1'b1;
        while ((idx < v.size() || sb.size() > 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (idx < v.size()) apply(v[idx]); else idle();
            #1;
            if (out_valid_o && out_ready_i) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL round_extra: got result %h with nothing expected", out_result_o);
                end else begin
                    x = sb.pop_front();
                    if (out_result_o !== x[9:0]) begin n_err++; $display("FAIL round_result: got %h want %h", out_result_o, x[9:0]); end
                    n_cmp++;
                    if (out_fflags_o !== x[14:10]) begin n_err++; $display("FAIL round_fflags: got %b want %b (result %h)", out_fflags_o, x[14:10], x[9:0]); end
                end
            end
            if (in_valid_i && in_ready_o) begin sb.push_back(e[idx]); idx++; end
        end
        n_cmp++; if (cyc >= 100) begin n_err++; $display("FAIL round_timeout: sent %0d pending %0d", idx, sb.size()); end
        idle();
        sb.delete();
    endtask

    task automatic test_special();
        vec_t        v[$];
        logic [14:0] e[$];
        logic [14:0] x;
        int          idx = 0;
        int          cyc = 0;
        v.push_back(mk(1, 0, 3, 7'b1010101, 3'd0, 1, 0, 0, 1, 0, 0)); e.push_back({ffm(5'b10000), 10'h1F8});
        v.push_back(mk(1, 0, 3, 7'b1010101, 3'd0, 0, 1, 1, 0, 0, 0)); e.push_back({ffm(5'b00000), 10'h3F0});
        v.push_back(mk(1, 1, 7, 7'b1000011, 3'd1, 0, 1, 0, 1, 0, 0)); e.push_back({ffm(5'b10000), 10'h1F0});
        v.push_back(mk(0, 0, 0, 7'b0000000, 3'd2, 0, 0, 0, 0, 0, 1)); e.push_back({ffm(5'b00000), 10'h200});
        v.push_back(mk(0, 1, 0, 7'b0000000, 3'd0, 0, 0, 0, 0, 0, 1)); e.push_back({ffm(5'b00000), 10'h000});
        v.push_back(mk(0, 0, 9, 7'b1000000, 3'd0, 1, 1, 1, 0, 0, 1)); e.push_back({ffm(5'b00000), 10'h1F8});
        out_ready_i = 1'b1;
        while ((idx < v.size() || sb.size() > 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (idx < v.size()) apply(v[idx]); else idle();
            #1;
            if (out_valid_o && out_ready_i) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL special_extra: got result %h with nothing expected", out_result_o);
                end else begin
                    x = sb.pop_front();
                    if (out_result_o !== x[9:0]) begin n_err++; $display("FAIL special_result: got %h want %h", out_result_o, x[9:0]); end
                    n_cmp++;
                    if (out_fflags_o !== x[14:10]) begin n_err++; $display("FAIL special_fflags: got %b want %b (result %h)", out_fflags_o, x[14:10], x[9:0]); end
                end
            end
            if (in_valid_i && in_ready_o) begin sb.push_back(e[idx]); idx++; end
        end
        n_cmp++; if (cyc >= 100) begin n_err++; $display("FAIL special_timeout: sent %0d pending %0d", idx, sb.size()); end
        idle();
        sb.delete();
    endtask

    task automatic test_back_to_back(input int n);
        vec_t        v[$];
        logic [14:0] x;
        logic [9:0]  snap = '0;
        int          idx = 0;
        int          cyc = 0;
        int          hold = 0;
        int          got = 0;
        for (int i = 0; i < n; i++) v.push_back(rand_vec());
        while ((idx < n || sb.size() > 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready_i = !(out_valid_o && hold < 3);
            if (idx < n) apply(v[idx]); else idle();
            #1;
            if (!out_ready_i) begin
                n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready_o); end
                if (hold > 0) begin
                    n_cmp++; if (out_result_o !== snap) begin n_err++; $display("FAIL stall_stable: got %h want %h", out_result_o, snap); end
                end
                snap = out_result_o;
                hold++;
            end
            if (out_valid_o && out_ready_i) begin
                n_cmp++;
                got++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra: got result %h with nothing expected", out_result_o);
                end else begin
                    x = sb.pop_front();
                    if (out_result_o !== x[9:0]) begin n_err++; $display("FAIL b2b_result: got %h want %h", out_result_o, x[9:0]); end
                    n_cmp++;
                    if (out_fflags_o !== x[14:10]) begin n_err++; $display("FAIL b2b_fflags: got %b want %b (result %h)", out_fflags_o, x[14:10], x[9:0]); end
                end
            end
            if (in_valid_i && in_ready_o) begin sb.push_back(model(v[idx])); idx++; end
        end
        n_cmp++; if (got != n) begin n_err++; $display("FAIL b2b_count: got %0d results want %0d", got, n); end
        out_ready_i = 1'b1;
        idle();
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drained: out_valid %b want 0", out_valid_o); end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(rand_vec());
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid_o); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_dropped: cycle %0d out_valid %b want 0", i, out_valid_o); end
        end
        sb.delete();
    endtask

    initial begin
        rst         = 1'b1;
        out_ready_i = 1'b1;
        idle();
        test_reset();
        test_rounding();
        test_special();
        test_back_to_back(4);
        test_back_to_back(12);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
